calc_entry_ctrl: RTL and testbench

Keypad entry sequencer for the 8-bit four-function calculator. Converts a stream of decoded key events into decimal-accumulated binary operands, drives the data and clock-enable inputs of the A and B operand registers and the operator register, and issues a one-cycle start to the arithmetic unit on "=". It is the writing side of the operand registers: it produces the D/CE pairs those registers consume, and it tracks the arithmetic unit's completion.

---
 rtl/calc_pkg.sv | 11 +
 rtl/calc_entry_ctrl_if.sv | 18 +
 rtl/dec_accum.sv | 14 +
 rtl/calc_entry_ctrl.sv | 104 ++++++++++
 tb/tb_calc_entry_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: key codes, operator and entry-state types for the keypad calculator
package calc_pkg;
  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
  typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, EXEC, RESULT} state_t;
endpackage

// File: rtl/calc_entry_ctrl_if.sv
// calc_entry_ctrl_if: keypad/arith-unit side (master) and entry controller side (slave)
interface calc_entry_ctrl_if import calc_pkg::*; #(parameter int W = 8);
  logic         KEY_VALID;
  logic [3:0]   KEY_CODE;
  logic         DONE;
  logic [W-1:0] OPND_D;
  logic         CE_A;
  logic         CE_B;
  op_t          OP;
  logic         OP_CE;
  logic         START;
  logic         OVF;
  logic         BUSY;
  modport master (output KEY_VALID, KEY_CODE, DONE,
                  input OPND_D, CE_A, CE_B, OP, OP_CE, START, OVF, BUSY);
  modport slave (input KEY_VALID, KEY_CODE, DONE,
                 output OPND_D, CE_A, CE_B, OP, OP_CE, START, OVF, BUSY);
endinterface

// File: rtl/dec_accum.sv
// dec_accum: one decimal step ACC*10+d with overflow detection beyond W bits
module dec_accum #(parameter int W = 8) (
  input  logic [W-1:0] i_acc,
  input  logic [3:0]   i_d,
  output logic [W-1:0] o_next,
  output logic         o_ovf
);
  logic [W+3:0] w_acc;
  logic [W+3:0] w_wide;
  assign w_acc  = {4'b0, i_acc};
  assign w_wide = (w_acc << 3) + (w_acc << 1) + {{W{1'b0}}, i_d};
  assign o_next = w_wide[W-1:0];
  assign o_ovf  = |w_wide[W+3:W];
endmodule

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad entry sequencer driving operand/operator register loads and
// the arithmetic unit start; every output is a register cleared by CLR.
module calc_entry_ctrl import calc_pkg::*; #(parameter int W = 8) (
  input logic CLK,
  input logic CLR,
  calc_entry_ctrl_if.slave bus
);
  state_t       r_state, w_nstate;
  logic [W-1:0] r_acc, w_acc, r_opnd_d, w_opnd_d, w_next, w_key;
  op_t          r_op, w_op;
  logic         r_ce_a, w_ce_a, r_ce_b, w_ce_b, r_op_ce, w_op_ce;
  logic         r_start, w_start, r_ovf, w_ovf, r_busy;
  logic         w_digit, w_oper, w_eq, w_clr, w_load, w_accum, w_acc_ovf;
  logic [3:0]   w_opc;
  assign w_digit = bus.KEY_VALID && bus.KEY_CODE <= 4'd9;
  assign w_oper  = bus.KEY_VALID && bus.KEY_CODE >= KEY_ADD && bus.KEY_CODE <= KEY_DIV;
  assign w_eq    = bus.KEY_VALID && bus.KEY_CODE == KEY_EQ;
  assign w_clr   = bus.KEY_VALID && bus.KEY_CODE == KEY_CLR;
  assign w_key   = {{(W-4){1'b0}}, bus.KEY_CODE};
  assign w_opc   = bus.KEY_CODE - KEY_ADD;
  // first digit of a fresh operand loads directly; later digits accumulate
  assign w_load  = w_digit && (r_state == OP_WAIT || r_state == RESULT);
  assign w_accum = w_digit && (r_state == ENTER_A || r_state == ENTER_B);
  dec_accum #(.W(W)) u_dec (.i_acc(r_acc), .i_d(bus.KEY_CODE), .o_next(w_next), .o_ovf(w_acc_ovf));
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      r_state  <= ENTER_A;
      r_acc    <= '0;
      r_opnd_d <= '0;
      r_op     <= OP_ADD;
      r_ce_a   <= 1'b0;
      r_ce_b   <= 1'b0;
      r_op_ce  <= 1'b0;
      r_start  <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_acc    <= w_acc;
      r_opnd_d <= w_opnd_d;
      r_op     <= w_op;
      r_ce_a   <= w_ce_a;
      r_ce_b   <= w_ce_b;
      r_op_ce  <= w_op_ce;
      r_start  <= w_start;
      r_ovf    <= w_ovf;
      r_busy   <= w_nstate == EXEC;
    end
  // clear beats everything, and in EXEC DONE beats any other key
  always_comb begin
    w_nstate = r_state;
    if (w_clr) w_nstate = ENTER_A;
    else
      case (r_state)
        ENTER_A: w_nstate = w_oper ? OP_WAIT : ENTER_A;
        OP_WAIT: w_nstate = w_digit ? ENTER_B : OP_WAIT;
        ENTER_B: w_nstate = w_eq ? EXEC : ENTER_B;
        EXEC:    w_nstate = bus.DONE ? RESULT : EXEC;
        RESULT:  w_nstate = w_digit ? ENTER_A : RESULT;
        default: w_nstate = ENTER_A;
      endcase
  end
  always_comb begin
    w_acc    = r_acc;
    w_opnd_d = r_opnd_d;
    w_op     = r_op;
    w_ce_a   = 1'b0;
    w_ce_b   = 1'b0;
    w_op_ce  = 1'b0;
    w_start  = 1'b0;
    w_ovf    = 1'b0;
    if (w_clr) begin
      w_acc    = '0;
      w_opnd_d = '0;
      w_ce_a   = 1'b1;
      w_ce_b   = 1'b1;
    end else if (w_load) begin
      w_acc    = w_key;
      w_opnd_d = w_key;
      w_ce_a   = r_state == RESULT;
      w_ce_b   = r_state == OP_WAIT;
    end else if (w_accum) begin
      w_acc    = w_acc_ovf ? r_acc : w_next;
      w_opnd_d = w_acc_ovf ? r_opnd_d : w_next;
      w_ce_a   = !w_acc_ovf && r_state == ENTER_A;
      w_ce_b   = !w_acc_ovf && r_state == ENTER_B;
      w_ovf    = w_acc_ovf;
    end else if (w_oper && (r_state == ENTER_A || r_state == OP_WAIT)) begin
      w_op     = op_t'(w_opc[1:0]);
      w_op_ce  = 1'b1;
      w_acc    = '0;
    end else if (w_eq && r_state == ENTER_B) begin
      w_start  = 1'b1;
    end
  end
  assign bus.OPND_D = r_opnd_d;
  assign bus.CE_A   = r_ce_a;
  assign bus.CE_B   = r_ce_b;
  assign bus.OP     = r_op;
  assign bus.OP_CE  = r_op_ce;
  assign bus.START  = r_start;
  assign bus.OVF    = r_ovf;
  assign bus.BUSY   = r_busy;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl: scoreboard bench; a keypad-level model queues the expected
// output snapshot for every pulse and a negedge monitor checks each DUT pulse.
module tb_calc_entry_ctrl;
  typedef struct packed {
    logic [7:0] d;
    logic       ce_a, ce_b;
    logic [1:0] op;
    logic       op_ce, start, ovf, busy;
  } obs_t;
  localparam int PH_A = 0, PH_OPW = 1, PH_B = 2, PH_EX = 3, PH_RES = 4;
  logic CLK = 1'b0;
  logic CLR = 1'b0;
  int   n_chk = 0, n_fail = 0;
  int   m_ph, m_acc, m_d, m_op;
  obs_t q[$];
  always #5 CLK = ~CLK;
  calc_entry_ctrl_if #(.W(8)) bus();
  calc_entry_ctrl #(.W(8)) dut (.CLK(CLK), .CLR(CLR), .bus(bus));
  function automatic obs_t sample();
    obs_t s;
    s.d = bus.OPND_D; s.ce_a = bus.CE_A; s.ce_b = bus.CE_B; s.op = bus.OP;
    s.op_ce = bus.OP_CE; s.start = bus.START; s.ovf = bus.OVF; s.busy = bus.BUSY;
    return s;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    m_ph = PH_A; m_acc = 0; m_d = 0; m_op = 0;
  endtask
  // keypad semantics: a key either changes nothing or yields exactly one pulse snapshot
  task automatic model(input bit kv, input int kc, input bit dn);
    obs_t e;
    int   n;
    e = '0;
    if (kv && kc == 15) begin
      m_acc = 0; m_d = 0; e.ce_a = 1; e.ce_b = 1; m_ph = PH_A;
    end else if (m_ph == PH_EX) begin
      if (dn) m_ph = PH_RES;
    end else if (kv) begin
      if (kc < 10) begin
        if (m_ph == PH_OPW || m_ph == PH_RES) begin
          m_acc = kc; m_d = kc;
          if (m_ph == PH_OPW) begin e.ce_b = 1; m_ph = PH_B; end
          else begin e.ce_a = 1; m_ph = PH_A; end
        end else begin
          n = m_acc * 10 + kc;
          if (n > 255) e.ovf = 1;
          else begin
            m_acc = n; m_d = n;
            if (m_ph == PH_A) e.ce_a = 1; else e.ce_b = 1;
          end
        end
      end else if (kc < 14 && (m_ph == PH_A || m_ph == PH_OPW)) begin
        m_op = kc - 10; e.op_ce = 1; m_acc = 0; m_ph = PH_OPW;
      end else if (kc == 14 && m_ph == PH_B) begin
        e.start = 1; m_ph = PH_EX;
      end
    end
    e.d = m_d[7:0]; e.op = m_op[1:0]; e.busy = m_ph == PH_EX;
    if (e.ce_a || e.ce_b || e.op_ce || e.start || e.ovf) q.push_back(e);
  endtask
  task automatic step(input bit kv, input int kc, input bit dn);
    @(posedge CLK);
    #1;
    bus.KEY_VALID = kv;
    bus.KEY_CODE  = kc[3:0];
    bus.DONE      = dn;
    model(kv, kc, dn);
  endtask
  task automatic keys(input int k[$]);
    foreach (k[i]) step(1, k[i], 0);
  endtask
  initial begin
    obs_t a, e;
    forever begin
      @(negedge CLK);
      if (CLR && (bus.CE_A || bus.CE_B || bus.OP_CE || bus.START || bus.OVF)) begin
        a = sample();
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse got=%p want=none", a);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL pulse got=%p want=%p", a, e);
          end
        end
      end
    end
  end
  initial begin
    int kc;
    bus.KEY_VALID = 0; bus.KEY_CODE = 0; bus.DONE = 0;
    model_reset();
    #12;
    chk("rst_opnd_d", bus.OPND_D, 0);
    chk("rst_ce_a", bus.CE_A, 0);
    chk("rst_ce_b", bus.CE_B, 0);
    chk("rst_op", int'(bus.OP), 0);
    chk("rst_op_ce", bus.OP_CE, 0);
    chk("rst_start", bus.START, 0);
    chk("rst_ovf", bus.OVF, 0);
    chk("rst_busy", bus.BUSY, 0);
    @(negedge CLK);
    CLR = 1;
    keys('{1, 2, 3, 15, 2, 5, 5, 6, 15, 2, 5, 6, 15});
    keys('{4, 10, 12, 7, 14});
    step(0, 0, 0);
    chk("busy_after_start", bus.BUSY, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("busy_after_done", bus.BUSY, 0);
    keys('{3, 10, 8, 14, 9, 14});
    step(1, 5, 1);
    keys('{5, 10, 4, 2, 15, 1, 11, 2, 14, 15});
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("busy_after_abort", bus.BUSY, 0);
    keys('{10, 3, 12, 7});
    @(posedge CLK);
    #2;
    CLR = 0;
    #1;
    chk("async_ce_b", bus.CE_B, 0);
    chk("async_opnd_d", bus.OPND_D, 0);
    chk("async_op", int'(bus.OP), 0);
    chk("async_busy", bus.BUSY, 0);
    bus.KEY_VALID = 0;
    q.delete();
    model_reset();
    @(negedge CLK);
    CLR = 1;
    keys('{3, 4});
    for (int i = 0; i < 3000; i++) begin
      kc = $urandom_range(0, 15);
      if (kc == 15 && $urandom_range(0, 3) != 0) kc = $urandom_range(0, 9);
      step(1'($urandom_range(0, 1)), kc, $urandom_range(0, 5) == 0);
    end
    step(0, 0, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
